tlul_host_rob_adapter: RTL and testbench

//  Next-gen TL-UL host adapter for the Ibex instr/data ports: converts Ibex req/gnt/rvalid into TL-UL A/D.

---
 rtl/tlul_host_rob_pkg.sv | 55 +++++
 rtl/tlul_host_rob_slot.sv | 33 +++
 rtl/tlul_host_rob_adapter.sv | 111 +++++++++++
 tb/tb_tlul_host_rob_adapter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_host_rob_pkg.sv
// tlul_host_rob_pkg: TL-UL channel types, ROB slot types and integrity helper for the host adapter.
package tlul_host_rob_pkg;
  localparam int unsigned MaxReqsMax = 8;
  localparam int unsigned TL_AW = 32;
  localparam int unsigned TL_DW = 32;
  localparam int unsigned TL_AIW = 8;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;
  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;
  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [3:0]        a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
  typedef enum logic [1:0] {FREE, PEND, DONE, ZOMBIE} slot_state_e;
  typedef struct packed {
    slot_state_e state;
    logic [31:0] rdata;
    logic        err;
  } slot_t;
  function automatic logic [6:0] intg7(input logic [63:0] d);
    logic [6:0] r;
    r = {6'h0, d[63]};
    for (int i = 0; i < 9; i++) r ^= d[i*7 +: 7];
    return r;
  endfunction
endpackage

// File: rtl/tlul_host_rob_slot.sv
// tlul_host_rob_slot: one reorder-buffer slot holding state, captured read data and error.
// TLUL_HOST_TIMEOUT_EN adds the expire input and the ZOMBIE state.
module tlul_host_rob_slot
  import tlul_host_rob_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alloc,
  input  logic        capture,
  input  logic        rel,
`ifdef TLUL_HOST_TIMEOUT_EN
  input  logic        expire,
`endif
  input  logic [31:0] rdata,
  input  logic        err,
  output slot_t       q
);
  slot_t d;
  always_comb begin
    d = q;
    if (q.state == FREE && alloc) d = '{state: PEND, rdata: '0, err: 1'b0};
    if (q.state == PEND && capture) d = '{state: DONE, rdata: rdata, err: err};
    if (q.state == DONE && rel) d.state = FREE;
`ifdef TLUL_HOST_TIMEOUT_EN
    // a response racing the timeout frees the slot instead of leaving a zombie forever
    if (q.state == PEND && expire) d = '{state: capture ? FREE : ZOMBIE, rdata: '0, err: 1'b0};
    if (q.state == ZOMBIE && capture) d.state = FREE;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q <= '0;
    else q <= d;
endmodule

// File: rtl/tlul_host_rob_adapter.sv
// tlul_host_rob_adapter: Ibex req/gnt/rvalid to TL-UL host with in-order release of out-of-order responses.
// TLUL_HOST_TIMEOUT_EN enables the head-slot response timeout.
module tlul_host_rob_adapter
  import tlul_host_rob_pkg::*;
#(
  parameter int unsigned MaxReqs       = 2,
  parameter int unsigned IdBase        = 0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  instr_type_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        unexp_rsp_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);
  localparam int unsigned PtrW = $clog2(MaxReqsMax);
  slot_t slot_q [MaxReqsMax];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [TL_AIW-1:0] src_off;
  logic [TL_DW-1:0] d_rdata;
  logic a_valid, rel, expire, unexp;
  slot_state_e head_state, d_state;
  tl_a_op_e op;
  logic unused_d;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxReqs - 1)) ? '0 : p + 1'b1;
  endfunction
  assign head_state = slot_q[rd_ptr].state;
  assign a_valid = req_i && slot_q[wr_ptr].state == FREE;
  assign gnt_o = a_valid && tl_i.a_ready;
  assign op = !we_i ? Get : (be_i == 4'hF ? PutFullData : PutPartialData);
  always_comb begin
    tl_o = '0;
    tl_o.a_valid = a_valid;
    tl_o.a_opcode = op;
    tl_o.a_size = 2'd2;
    tl_o.a_source = TL_AIW'(IdBase + wr_ptr);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask = be_i;
    tl_o.a_data = wdata_i;
    tl_o.a_user.instr_type = instr_type_i;
    tl_o.a_user.cmd_intg = intg7({21'h0, instr_type_i, addr_i[31:2], 2'b00, op, be_i});
    tl_o.a_user.data_intg = intg7({32'h0, wdata_i});
    tl_o.d_ready = 1'b1;
  end
  assign src_off = tl_i.d_source - TL_AIW'(IdBase);
  assign d_state = slot_q[src_off[PtrW-1:0]].state;
  assign d_rdata = (tl_i.d_opcode == AccessAckData && !tl_i.d_error) ? tl_i.d_data : '0;
  assign unexp = tl_i.d_valid && (src_off >= TL_AIW'(MaxReqs) || (d_state != PEND && d_state != ZOMBIE));
  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};
  assign rel = head_state == DONE;
  assign valid_o = rel || expire;
  assign err_o = rel ? slot_q[rd_ptr].err : expire;
  assign rdata_o = rel ? slot_q[rd_ptr].rdata : '0;
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < MaxReqsMax; i++) busy_o |= slot_q[i].state != FREE;
  end
  for (genvar k = 0; k < MaxReqsMax; k++) begin : g_slot
    if (k < MaxReqs) begin : g_on
      tlul_host_rob_slot u_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .alloc   (gnt_o && wr_ptr == PtrW'(k)),
        .capture (tl_i.d_valid && src_off == TL_AIW'(k)),
        .rel     (rel && rd_ptr == PtrW'(k)),
`ifdef TLUL_HOST_TIMEOUT_EN
        .expire  (expire && rd_ptr == PtrW'(k)),
`endif
        .rdata   (d_rdata),
        .err     (tl_i.d_error),
        .q       (slot_q[k])
      );
    end else begin : g_off
      assign slot_q[k] = '0;
    end
  end
`ifdef TLUL_HOST_TIMEOUT_EN
  logic [31:0] to_cnt;
  assign expire = head_state == PEND && to_cnt == 32'(TimeoutCycles - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) to_cnt <= '0;
    else to_cnt <= (head_state == PEND && !expire) ? to_cnt + 32'd1 : '0;
`else
  logic unused_timeout;
  assign expire = 1'b0;
  assign unused_timeout = ^TimeoutCycles;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (gnt_o) wr_ptr <= inc(wr_ptr);
      if (valid_o) rd_ptr <= inc(rd_ptr);
      if (unexp) unexp_rsp_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tlul_host_rob_adapter.sv
// tb_tlul_host_rob_adapter: directed self-checking bench for the TL-UL ROB host adapter (MaxReqs=2).
module tb_tlul_host_rob_adapter;
  import tlul_host_rob_pkg::*;
  logic clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic gnt_o, valid_o, err_o, busy_o, unexp_rsp_o;
  logic [31:0] addr_i = '0, wdata_i = '0, rdata_o;
  logic [3:0] be_i = 4'hF, instr_type_i = 4'h9;
  tl_h2d_t tl_o;
  tl_d2h_t tl_i;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  tlul_host_rob_adapter #(.MaxReqs(2), .IdBase(0), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .instr_type_i(instr_type_i), .valid_o(valid_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o), .unexp_rsp_o(unexp_rsp_o), .tl_o(tl_o), .tl_i(tl_i)
  );
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic d_idle;
    tl_i = '0;
    tl_i.a_ready = 1'b1;
  endtask
  task automatic d_beat(input logic [7:0] src, input logic [31:0] data, input logic err, input tl_d_op_e opc);
    tl_i.d_valid = 1'b1;
    tl_i.d_source = src;
    tl_i.d_data = data;
    tl_i.d_error = err;
    tl_i.d_opcode = opc;
  endtask
  task automatic do_reset;
    req_i = 1'b0;
    we_i = 1'b0;
    be_i = 4'hF;
    d_idle();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask
  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (valid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_rsp got valid=%b err=%b rdata=%h exp 0 0 0", valid_o, err_o, rdata_o);
    end
    checks++;
    if (busy_o !== 1'b0 || unexp_rsp_o !== 1'b0 || tl_o.a_valid !== 1'b0 || tl_o.d_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ctl got busy=%b unexp=%b a_valid=%b d_ready=%b exp 0 0 0 1", busy_o, unexp_rsp_o, tl_o.a_valid, tl_o.d_ready);
    end
  endtask
  task automatic test_single_get;
    do_reset();
    req_i = 1'b1; addr_i = 32'h1000_0004; #1;
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt got %b exp 1", gnt_o); end
    checks++;
    if (tl_o.a_opcode !== Get || tl_o.a_address !== 32'h1000_0004 || tl_o.a_source !== 8'd0 || tl_o.a_size !== 2'd2 || tl_o.a_user.instr_type !== 4'h9) begin
      errors++; $display("FAIL single_afields got op=%0h addr=%h src=%0d size=%0d it=%h exp 4 10000004 0 2 9", tl_o.a_opcode, tl_o.a_address, tl_o.a_source, tl_o.a_size, tl_o.a_user.instr_type);
    end
    step();
    req_i = 1'b0; d_beat(8'd0, 32'hDEAD_BEEF, 1'b0, AccessAckData); #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_dcycle got valid=%b busy=%b exp 0 1", valid_o, busy_o); end
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
      errors++; $display("FAIL single_rsp got valid=%b rdata=%h err=%b exp 1 deadbeef 0", valid_o, rdata_o, err_o);
    end
    step(); #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_after got valid=%b busy=%b exp 0 0", valid_o, busy_o); end
  endtask
  task automatic test_reorder;
    do_reset();
    req_i = 1'b1; addr_i = 32'h100; #1;
    checks++;
    if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin errors++; $display("FAIL reorder_gnt0 got gnt=%b src=%0d exp 1 0", gnt_o, tl_o.a_source); end
    step();
    addr_i = 32'h200; #1;
    checks++;
    if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd1 || tl_o.a_address !== 32'h200) begin
      errors++; $display("FAIL reorder_gnt1 got gnt=%b src=%0d addr=%h exp 1 1 200", gnt_o, tl_o.a_source, tl_o.a_address);
    end
    step();
    req_i = 1'b0; d_beat(8'd1, 32'h11, 1'b0, AccessAckData); #1;
    step();
    d_beat(8'd0, 32'h22, 1'b0, AccessAckData); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reorder_hold got valid=%b exp 0", valid_o); end
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h22) begin errors++; $display("FAIL reorder_first got valid=%b rdata=%h exp 1 22", valid_o, rdata_o); end
    step(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h11) begin errors++; $display("FAIL reorder_second got valid=%b rdata=%h exp 1 11", valid_o, rdata_o); end
    step(); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reorder_end got valid=%b exp 0", valid_o); end
  endtask
  task automatic test_partial_write;
    do_reset();
    tl_i.a_ready = 1'b0; req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'hA5A5_0F0F; addr_i = 32'h2000_0007; #1;
    checks++;
    if (tl_o.a_valid !== 1'b1 || gnt_o !== 1'b0 || tl_o.a_opcode !== PutFullData || tl_o.a_address !== 32'h2000_0004 || tl_o.a_data !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL write_full got a_valid=%b gnt=%b op=%0h addr=%h data=%h exp 1 0 0 20000004 a5a50f0f", tl_o.a_valid, gnt_o, tl_o.a_opcode, tl_o.a_address, tl_o.a_data);
    end
    be_i = 4'h3; tl_i.a_ready = 1'b1; #1;
    checks++;
    if (tl_o.a_opcode !== PutPartialData || tl_o.a_mask !== 4'h3 || gnt_o !== 1'b1) begin
      errors++; $display("FAIL write_partial got op=%0h mask=%h gnt=%b exp 1 3 1", tl_o.a_opcode, tl_o.a_mask, gnt_o);
    end
    step();
    req_i = 1'b0; we_i = 1'b0; d_beat(8'd0, 32'hCAFE_F00D, 1'b1, AccessAck); #1;
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL write_err got valid=%b err=%b rdata=%h exp 1 1 0", valid_o, err_o, rdata_o);
    end
  endtask
  task automatic test_full;
    do_reset();
    req_i = 1'b1; addr_i = 32'h300; #1;
    step();
    step();
    d_beat(8'd0, 32'h33, 1'b0, AccessAckData); #1;
    checks++;
    if (gnt_o !== 1'b0 || tl_o.a_valid !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL full_stall got gnt=%b a_valid=%b busy=%b exp 0 0 1", gnt_o, tl_o.a_valid, busy_o);
    end
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h33 || gnt_o !== 1'b0) begin
      errors++; $display("FAIL full_release got valid=%b rdata=%h gnt=%b exp 1 33 0", valid_o, rdata_o, gnt_o);
    end
    step(); #1;
    checks++;
    if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0) begin errors++; $display("FAIL full_regrant got gnt=%b src=%0d exp 1 0", gnt_o, tl_o.a_source); end
    step();
    req_i = 1'b0;
  endtask
  task automatic test_unexpected;
    do_reset();
    req_i = 1'b1; #1;
    step();
    req_i = 1'b0; d_beat(8'd5, 32'h99, 1'b0, AccessAckData); #1;
    checks++;
    if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_early got %b exp 0", unexp_rsp_o); end
    step();
    d_idle(); #1;
    checks++;
    if (unexp_rsp_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL unexp_range got unexp=%b valid=%b busy=%b exp 1 0 1", unexp_rsp_o, valid_o, busy_o);
    end
    d_beat(8'd0, 32'h44, 1'b0, AccessAckData); #1;
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h44 || unexp_rsp_o !== 1'b1) begin
      errors++; $display("FAIL unexp_slot got valid=%b rdata=%h unexp=%b exp 1 44 1", valid_o, rdata_o, unexp_rsp_o);
    end
    step();
    req_i = 1'b1; #1;
    step();
    do_reset(); #1;
    checks++;
    if (busy_o !== 1'b0 || unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL midreset got busy=%b unexp=%b exp 0 0", busy_o, unexp_rsp_o); end
    d_beat(8'd1, 32'h77, 1'b0, AccessAckData); #1;
    step();
    d_idle(); #1;
    checks++;
    if (unexp_rsp_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL late_beat got unexp=%b valid=%b exp 1 0", unexp_rsp_o, valid_o); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    req_i = 1'b1; #1;
    step();
    step();
    req_i = 1'b0; d_beat(8'd0, 32'hA0, 1'b0, AccessAckData); #1;
    step();
    d_beat(8'd1, 32'hB1, 1'b0, AccessAckData); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'hA0) begin errors++; $display("FAIL b2b_first got valid=%b rdata=%h exp 1 a0", valid_o, rdata_o); end
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'hB1) begin errors++; $display("FAIL b2b_second got valid=%b rdata=%h exp 1 b1", valid_o, rdata_o); end
    step(); #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL b2b_end got valid=%b busy=%b exp 0 0", valid_o, busy_o); end
  endtask
  task automatic test_timeout;
    int first;
    first = 0;
    do_reset();
    req_i = 1'b1; #1;
    step();
    req_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (valid_o === 1'b1) begin
        first = i;
        break;
      end
      step();
    end
`ifdef TLUL_HOST_TIMEOUT_EN
    checks++;
    if (first !== 16 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL timeout_rsp got cycle=%0d err=%b rdata=%h exp 16 1 0", first, err_o, rdata_o);
    end
    step();
    req_i = 1'b1; #1;
    checks++;
    if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd1) begin errors++; $display("FAIL timeout_next got gnt=%b src=%0d exp 1 1", gnt_o, tl_o.a_source); end
    step();
    d_beat(8'd1, 32'h55, 1'b0, AccessAckData); #1;
    checks++;
    if (gnt_o !== 1'b0) begin errors++; $display("FAIL zombie_alloc got gnt=%b exp 0", gnt_o); end
    step();
    d_idle(); #1;
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h55) begin errors++; $display("FAIL timeout_slot1 got valid=%b rdata=%h exp 1 55", valid_o, rdata_o); end
    step();
    d_beat(8'd0, 32'h66, 1'b0, AccessAckData); #1;
    checks++;
    if (gnt_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL zombie_late got gnt=%b valid=%b exp 0 0", gnt_o, valid_o); end
    step();
    d_idle(); #1;
    checks++;
    if (gnt_o !== 1'b1 || tl_o.a_source !== 8'd0 || unexp_rsp_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL zombie_free got gnt=%b src=%0d unexp=%b valid=%b exp 1 0 0 0", gnt_o, tl_o.a_source, unexp_rsp_o, valid_o);
    end
    step();
    req_i = 1'b0;
`else
    checks++;
    if (first !== 0 || busy_o !== 1'b1) begin errors++; $display("FAIL no_timeout got cycle=%0d busy=%b exp 0 1", first, busy_o); end
`endif
  endtask
  initial begin
    d_idle();
    test_reset();
    test_single_get();
    test_reorder();
    test_partial_write();
    test_full();
    test_unexpected();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
